uart_rx_fifo_apb: RTL and testbench
===================================

# uart_rx_fifo_apb

Receive-side companion to the UART transmit FIFO bridge. Accepts bytes from the UART receiver core and buffers them in an internal FIFO. Exposes the bytes, FIFO status, overflow and a level-threshold interrupt to the CPU through a simple APB-style slave port. Sits between the UART RX serializer and the APB interconnect.

## Interface
Parameters:
- DEPTH, 16: FIFO depth in bytes; power of two, 2..128.
- AW, 32: address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- paddr  in  AW  register address; byte offsets 0x0, 0x4, 0x8, 0xC; others read 0 and ignore writes.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  32  write data.
- prdata  out  32  read data, registered.
- rx_data  in  8  received byte from UART core.
- rx_data_valid  in  1  one-cycle strobe; rx_data valid.
- rx_irq  out  1  interrupt, registered, level.
- fifo_level  out  8  current occupancy 0..DEPTH.

## Operation
Register map:
- 0x0 RXDATA (RO).
  - Read returns {bit31 = empty, 23'b0, head byte}.
  - Head byte reads 0 when the FIFO is empty.
- 0x4 CONTROL (RW).
  - bit0 rx_en, reset 1.
  - bit1 irq_en, reset 0.
  - bit2 flush: write-1 self-clearing, reads 0.
- 0x8 STATUS.
  - bit0 empty (RO).
  - bit1 full (RO).
  - bit2 overflow: sticky, write-1-to-clear.
  - bits[15:8] level (RO).
- 0xC THRESHOLD (RW), bits[7:0], reset 1.
  - Value 0 is treated as 1.
  - Values > DEPTH never trigger.

Access phases:
- Setup phase = psel & ~penable. Access phase = psel & penable.
- Reads: prdata is loaded in the setup phase and held through the access phase; 0 otherwise.
- Writes take effect at the end of the access phase.

FIFO behaviour:
- Push: rx_data_valid & rx_en & ~full & ~flush.
  - Write the byte at wr_ptr, then increment.
  - Pointers are log2(DEPTH)+1 bits wide; wrap modulo 2·DEPTH.
  - full = MSBs differ and lower bits equal. empty = pointers equal.
- rx_data_valid & rx_en & full: byte dropped, overflow set.
- rx_data_valid & ~rx_en: byte dropped, overflow unchanged.
- Pop: access-phase read of 0x0 with FIFO non-empty advances rd_ptr. A read of an empty FIFO does not pop.

Simultaneous events:
- Push and pop in the same cycle: both occur, level unchanged. This is allowed when full; pop frees the slot first.
- Flush: both pointers reset to 0 and level becomes 0. It overrides a same-cycle push and pop; that byte is dropped and overflow is not set.
- Overflow set and W1C in the same cycle: set wins.

Interrupt:
- rx_irq next = irq_en & ((level ≥ max(THRESHOLD,1)) | overflow).

## Timing
- Reset values:
  - prdata = 0, rx_irq = 0, fifo_level = 0.
  - Pointers = 0, overflow = 0.
  - CONTROL = 0x1, THRESHOLD = 1.
- Push latency:
  - fifo_level increments on the edge that samples rx_data_valid.
  - The byte is readable via RXDATA from a setup phase starting the next cycle.
- Pop: level decrements on the edge ending the access phase. A back-to-back read, with the next setup in the following cycle, returns the next byte.
- rx_irq: asserts/deasserts one cycle after the condition changes.
- Status and level bits read in a setup phase reflect state before that cycle's edge.
- Reset mid-operation: all state clears immediately (asynchronous). Buffered bytes are lost.
- rx_data_valid is sampled every cycle; back-to-back strobes are legal.

## Test plan
- Basic order: reset.
  - Push 0x41, 0x42, 0x43 on consecutive cycles -> fifo_level = 3.
  - Three RXDATA reads return 0x41, 0x42, 0x43 (bit31 = 0); the fourth returns 0x80000000.
- Full/overflow with DEPTH = 16: push 17 bytes 0x00..0x10.
  - STATUS = 0x1006 (level 16, full, overflow).
  - Reads return 0x00..0x0F; byte 0x10 is lost.
  - Write STATUS 0x4 -> overflow reads 0.
- Simultaneous push/pop at full:
  - FIFO full; push 0xAA in the same cycle as an RXDATA access phase -> level stays 16, no overflow.
  - The last byte read after draining = 0xAA.
- Interrupt:
  - CONTROL = 0x3, THRESHOLD = 4. Push 3 bytes -> rx_irq = 0.
  - 4th push -> rx_irq = 1 one cycle later.
  - One read -> rx_irq = 0 one cycle after the pop.
- Flush/disable:
  - Push 5 bytes, then write CONTROL = 0x5 -> level 0, empty = 1, flush reads back 0.
  - Write CONTROL = 0x0, push 0x55 -> level 0, overflow 0.
- Reset mid-stream: push 6 bytes, then assert resetn low for one cycle -> level 0, rx_irq 0, CONTROL reads 0x1, THRESHOLD reads 1.

Source files
------------

// File: rtl/uart_rx_fifo_apb.sv
// uart_rx_fifo_apb: buffers bytes from the UART receiver in a FIFO and exposes data,
// status, overflow and a level-threshold interrupt through an APB-style slave port.
module uart_rx_fifo_apb #(
    parameter int DEPTH = 16,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] paddr_i,
    input  logic          psel_i,
    input  logic          penable_i,
    input  logic          pwrite_i,
    input  logic [31:0]   pwdata_i,
    output logic [31:0]   prdata_o,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_data_valid_i,
    output logic          rx_irq_o,
    output logic [7:0]    fifo_level_o
);
    localparam int PW = $clog2(DEPTH) + 1;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, diff;
    logic          rx_en_q, rx_en_d, irq_en_q, irq_en_d, ovf_q, ovf_d, irq_q, irq_d;
    logic [7:0]    thr_q, thr_d, thr_eff, level, head;
    logic [31:0]   prdata_q, prdata_d, rdata;
    logic          setup, access, wr, rd, a0, a1, a2, a3;
    logic          empty, full, flush, pop, push, ovf_set, ovf_clr;
    logic          unused_ok;
    assign unused_ok = ^pwdata_i[31:8];
    assign a0 = paddr_i == AW'(32'h0);
    assign a1 = paddr_i == AW'(32'h4);
    assign a2 = paddr_i == AW'(32'h8);
    assign a3 = paddr_i == AW'(32'hC);
    assign setup  = psel_i & ~penable_i;
    assign access = psel_i & penable_i;
    assign wr = access & pwrite_i;
    assign rd = access & ~pwrite_i;
    assign diff  = wr_ptr_q - rd_ptr_q;
    assign level = 8'(diff);
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign head  = empty ? 8'h00 : mem_q[rd_ptr_q[PW-2:0]];
    assign flush = wr & a1 & pwdata_i[2];
    assign pop   = rd & a0 & ~empty;
    // a pop in the same cycle frees the slot, so a push at full is still accepted
    assign push    = rx_data_valid_i & rx_en_q & (~full | pop) & ~flush;
    assign ovf_set = rx_data_valid_i & rx_en_q & full & ~pop & ~flush;
    assign ovf_clr = wr & a2 & pwdata_i[2];
    assign thr_eff = (thr_q == 8'd0) ? 8'd1 : thr_q;
    always_comb begin
        rdata    = a0 ? {empty, 23'b0, head} :
                   a1 ? {29'b0, 1'b0, irq_en_q, rx_en_q} :
                   a2 ? {16'b0, level, 5'b0, ovf_q, full, empty} :
                   a3 ? {24'b0, thr_q} : 32'b0;
        prdata_d = (setup & ~pwrite_i) ? rdata : (access & ~pwrite_i) ? prdata_q : 32'b0;
        wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
        rx_en_d  = (wr & a1) ? pwdata_i[0] : rx_en_q;
        irq_en_d = (wr & a1) ? pwdata_i[1] : irq_en_q;
        thr_d    = (wr & a3) ? pwdata_i[7:0] : thr_q;
        ovf_d    = ovf_set | (ovf_q & ~ovf_clr);
        irq_d    = irq_en_q & ((level >= thr_eff) | ovf_q);
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rx_en_q  <= 1'b1;
            irq_en_q <= 1'b0;
            thr_q    <= 8'd1;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            prdata_q <= 32'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rx_en_q  <= rx_en_d;
            irq_en_q <= irq_en_d;
            thr_q    <= thr_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            prdata_q <= prdata_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PW-2:0]] <= rx_data_i;
    end
    assign prdata_o     = prdata_q;
    assign rx_irq_o     = irq_q;
    assign fifo_level_o = level;
endmodule

// File: tb/tb_uart_rx_fifo_apb.sv
// tb_uart_rx_fifo_apb: register table, directed corner sequences and a randomized run
// checked against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo_apb;
    localparam int DEPTH = 16;
    logic        clk = 0, resetn = 0;
    logic [31:0] paddr = 0, pwdata = 0, prdata;
    logic        psel = 0, penable = 0, pwrite = 0;
    logic [7:0]  rx_data = 0, fifo_level;
    logic        rx_valid = 0, rx_irq;
    int          n_vec = 0, n_err = 0;

    uart_rx_fifo_apb #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk(clk), .resetn(resetn), .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata), .rx_data_i(rx_data),
        .rx_data_valid_i(rx_valid), .rx_irq_o(rx_irq), .fifo_level_o(fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk); paddr = a; pwdata = d; pwrite = 1; psel = 1; penable = 0;
        @(negedge clk); penable = 1;
        @(negedge clk); psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); paddr = a; pwrite = 0; psel = 1; penable = 0;
        @(negedge clk); penable = 1; d = prdata;
        @(negedge clk); psel = 0; penable = 0;
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); rx_valid = 1; rx_data = first + 8'(i);
        end
        @(negedge clk); rx_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); resetn = 0;
        @(negedge clk); resetn = 1;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[15];
    logic [31:0] r;
    logic [7:0]  q[$];
    logic        m_ovf, m_rxen, m_irqen;
    logic [7:0]  m_thr;

    initial begin
        tbl[0]  = '{0, 32'h0,  32'h0,         32'h8000_0000};
        tbl[1]  = '{0, 32'h4,  32'h0,         32'h1};
        tbl[2]  = '{0, 32'h8,  32'h0,         32'h1};
        tbl[3]  = '{0, 32'hC,  32'h0,         32'h1};
        tbl[4]  = '{0, 32'h10, 32'h0,         32'h0};
        tbl[5]  = '{1, 32'hC,  32'h1FF,       32'h0};
        tbl[6]  = '{0, 32'hC,  32'h0,         32'hFF};
        tbl[7]  = '{1, 32'h4,  32'hFFFF_FFFE, 32'h0};
        tbl[8]  = '{0, 32'h4,  32'h0,         32'h2};
        tbl[9]  = '{1, 32'h10, 32'hFFFF,      32'h0};
        tbl[10] = '{0, 32'h10, 32'h0,         32'h0};
        tbl[11] = '{0, 32'h4,  32'h0,         32'h2};
        tbl[12] = '{1, 32'h4,  32'h1,         32'h0};
        tbl[13] = '{1, 32'hC,  32'h1,         32'h0};
        tbl[14] = '{0, 32'h4,  32'h0,         32'h1};

        #1;
        chk("reset_level", 32'(fifo_level), 32'h0);
        chk("reset_irq", 32'(rx_irq), 32'h0);
        chk("reset_prdata", prdata, 32'h0);
        @(negedge clk); resetn = 1;

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) apb_write(tbl[i].addr, tbl[i].data);
            else begin
                apb_read(tbl[i].addr, r);
                chk($sformatf("table_%0d", i), r, tbl[i].exp);
            end
        end
        chk("table_irq", 32'(rx_irq), 32'h0);

        push_seq(8'h41, 3);
        chk("basic_level", 32'(fifo_level), 32'd3);
        for (int i = 0; i < 3; i++) begin
            apb_read(32'h0, r);
            chk("basic_read", r, 32'h41 + 32'(i));
        end
        apb_read(32'h0, r);
        chk("basic_empty_read", r, 32'h8000_0000);

        push_seq(8'h00, 17);
        apb_read(32'h8, r);
        chk("ovf_status", r, 32'h1006);
        for (int i = 0; i < 16; i++) begin
            apb_read(32'h0, r);
            chk("ovf_drain", r, 32'(i));
        end
        apb_read(32'h0, r);
        chk("ovf_lost", r, 32'h8000_0000);
        apb_write(32'h8, 32'h4);
        apb_read(32'h8, r);
        chk("ovf_w1c", r, 32'h1);

        push_seq(8'h10, 16);
        @(negedge clk); paddr = 0; pwrite = 0; psel = 1; penable = 0;
        @(negedge clk); penable = 1; rx_valid = 1; rx_data = 8'hAA; r = prdata;
        @(negedge clk); psel = 0; penable = 0; rx_valid = 0;
        chk("simul_pop_data", r, 32'h10);
        chk("simul_level", 32'(fifo_level), 32'd16);
        apb_read(32'h8, r);
        chk("simul_status", r, 32'h1002);
        for (int i = 0; i < 16; i++) apb_read(32'h0, r);
        chk("simul_last", r, 32'hAA);

        apb_write(32'h4, 32'h3);
        apb_write(32'hC, 32'h4);
        push_seq(8'h60, 3);
        @(negedge clk);
        chk("irq_below", 32'(rx_irq), 32'h0);
        push_seq(8'h63, 1);
        chk("irq_not_yet", 32'(rx_irq), 32'h0);
        @(negedge clk);
        chk("irq_set", 32'(rx_irq), 32'h1);
        apb_read(32'h0, r);
        chk("irq_still", 32'(rx_irq), 32'h1);
        @(negedge clk);
        chk("irq_clear", 32'(rx_irq), 32'h0);

        push_seq(8'h70, 5);
        chk("flush_pre_level", 32'(fifo_level), 32'd8);
        apb_write(32'h4, 32'h5);
        chk("flush_level", 32'(fifo_level), 32'd0);
        apb_read(32'h8, r);
        chk("flush_status", r, 32'h1);
        apb_read(32'h4, r);
        chk("flush_ctrl", r, 32'h1);
        apb_write(32'h4, 32'h0);
        push_seq(8'h55, 1);
        chk("disable_level", 32'(fifo_level), 32'd0);
        apb_read(32'h8, r);
        chk("disable_status", r, 32'h1);

        apb_write(32'h4, 32'h3);
        push_seq(8'h80, 6);
        @(negedge clk);
        chk("mid_irq_pre", 32'(rx_irq), 32'h1);
        resetn = 0;
        #1;
        chk("mid_level", 32'(fifo_level), 32'd0);
        chk("mid_irq", 32'(rx_irq), 32'h0);
        @(negedge clk); resetn = 1;
        apb_read(32'h4, r);
        chk("mid_ctrl", r, 32'h1);
        apb_read(32'hC, r);
        chk("mid_thr", r, 32'h1);
        apb_read(32'h8, r);
        chk("mid_status", r, 32'h1);

        // randomized run against a queue model, starting from a fresh reset
        do_reset();
        q = {}; m_ovf = 0; m_rxen = 1; m_irqen = 0; m_thr = 8'd1;
        for (int k = 0; k < 400; k++) begin
            int op;
            logic [7:0]  b;
            logic [31:0] d, e;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                b = 8'($urandom);
                push_seq(b, 1);
                if (m_rxen) begin
                    if (q.size() < DEPTH) q.push_back(b);
                    else m_ovf = 1;
                end
            end else if (op <= 5) begin
                apb_read(32'h0, d);
                e = (q.size() == 0) ? 32'h8000_0000 : {24'b0, q[0]};
                chk("rand_rxdata", d, e);
                if (q.size() != 0) void'(q.pop_front());
            end else if (op == 6) begin
                apb_read(32'h8, d);
                e = {16'b0, 8'(q.size()), 5'b0, m_ovf, q.size() == DEPTH, q.size() == 0};
                chk("rand_status", d, e);
            end else if (op == 7) begin
                d = $urandom;
                apb_write(32'h8, d);
                if (d[2]) m_ovf = 0;
            end else if (op == 8) begin
                d = {29'b0, $urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 3) != 0};
                apb_write(32'h4, d);
                m_rxen = d[0];
                m_irqen = d[1];
                if (d[2]) q = {};
            end else begin
                d = $urandom_range(0, 20);
                apb_write(32'hC, d);
                m_thr = d[7:0];
            end
            @(negedge clk);
            chk("rand_level", 32'(fifo_level), 32'(q.size()));
            chk("rand_irq", 32'(rx_irq),
                32'(m_irqen && (q.size() >= ((m_thr == 0) ? 1 : int'(m_thr)) || m_ovf)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
